// File: rtl/fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_unit_pkg
//   Shared constants and types for the instruction fetch unit.
//   NOP     : canonical no-op encoding (addi x0, x0, 0)
//   PC_STEP : byte distance between sequential instruction fetches
//   fetch_entry_t : one instruction-queue entry {pc, instr}
// -----------------------------------------------------------------------------
package fetch_unit_pkg;

  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage : fetch_unit_pkg

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
//   Small synchronous circular FIFO with flush. The head is presented
//   combinationally on rdata (zero while empty).
//   Ports:
//     clk_i  : clock, rising edge
//     rst_i  : synchronous active-low reset
//     push   : write wdata (taken when not full, or when full and popping)
//     wdata  : data to write
//     pop    : drop the head (ignored while empty)
//     flush  : empty the FIFO; overrides push and pop
//     rdata  : head entry, '0 when empty
//     count  : number of stored entries
//     full   : count == DEPTH
//     empty  : count == 0
// -----------------------------------------------------------------------------
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + AW'(1);
  endfunction

  assign full    = (cnt_q == CNT_FULL);
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (!rst_i || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CNT_ONE;
        2'b01:   cnt_q <= cnt_q - CNT_ONE;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; validity is carried entirely by
  // the pointers and count, and rdata is masked to zero while empty.
  always_ff @(posedge clk_i) begin
    if (rst_i && !flush && do_push) mem[wr_ptr] <= wdata;
  end

endmodule : fetch_fifo

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage. Issues sequential requests to instruction memory
//   under a credit limit (queued + in-flight <= DEPTH), pairs in-order
//   responses with their PCs and buffers them for the decode stage. A redirect
//   restarts fetching at a new word-aligned PC and discards every response
//   still owed by memory.
//   Ports:
//     clk_i, rst_i        : clock, synchronous active-low reset
//     start_i             : fetch enable
//     imem_req_o/addr_o   : request and its address (the PC register)
//     imem_gnt_i          : request accepted this cycle
//     imem_rvalid_i/rdata : in-order response
//     redirect_i/pc_i     : branch/jump redirect strobe and target
//     stall_i             : downstream not accepting this cycle
//     instr_valid_o, instr_o, instr_pc_o : instruction-queue head
// -----------------------------------------------------------------------------
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        stall_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]   CNT_ONE = CW'(1);
  localparam logic [CW:0]     CREDITS = (CW+1)'(DEPTH);
  localparam int              EW      = $bits(fetch_entry_t);

  logic [31:0]   pc_q;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] discard_q, discard_d;

  logic          grant;
  logic          rvalid_live;  // response that belongs to a request we own
  logic          accept;       // response kept and enqueued
  logic          drop;         // stale response after a redirect
  logic          dequeue;
  logic          credit_ok;

  logic [CW-1:0] q_count;
  logic          q_full, q_empty;
  logic [EW-1:0] q_rdata;
  fetch_entry_t  q_wentry, q_head;

  logic [31:0]   f_rdata;
  logic [CW-1:0] f_count;
  logic          f_full, f_empty;

  // ---------------------------------------------------------------------------
  // Request side
  // ---------------------------------------------------------------------------
  assign credit_ok   = ({1'b0, q_count} + {1'b0, outstanding_q}) < CREDITS;
  // Gating with rst_i keeps the request low during reset even though the
  // rest of the condition is combinational on live inputs.
  assign imem_req_o  = rst_i && start_i && !redirect_i && credit_ok;
  assign imem_addr_o = pc_q;
  assign grant       = imem_req_o && imem_gnt_i;

  // ---------------------------------------------------------------------------
  // Response side
  // ---------------------------------------------------------------------------
  // A response with nothing outstanding (e.g. one granted before a reset)
  // is ignored entirely.
  assign rvalid_live = imem_rvalid_i && (outstanding_q != '0);
  assign accept      = rvalid_live && (discard_q == '0);
  assign drop        = rvalid_live && (discard_q != '0);
  assign dequeue     = instr_valid_o && !stall_i;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    if (redirect_i) begin
      // Everything still owed by memory becomes stale, less a response that
      // lands in this very cycle.
      outstanding_d = outstanding_q - (rvalid_live ? CNT_ONE : '0);
      discard_d     = outstanding_d;
    end else begin
      if (grant && !rvalid_live)      outstanding_d = outstanding_q + CNT_ONE;
      else if (!grant && rvalid_live) outstanding_d = outstanding_q - CNT_ONE;
      if (drop)                       discard_d     = discard_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      if (redirect_i)  pc_q <= {redirect_pc_i[31:2], 2'b00};
      else if (grant)  pc_q <= pc_q + PC_STEP;
    end
  end

  // ---------------------------------------------------------------------------
  // In-flight PC FIFO: PCs of granted, not yet answered, non-stale requests.
  // ---------------------------------------------------------------------------
  fetch_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_inflight (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (grant),
    .wdata (pc_q),
    .pop   (accept),
    .flush (redirect_i),
    .rdata (f_rdata),
    .count (f_count),
    .full  (f_full),
    .empty (f_empty)
  );

  // ---------------------------------------------------------------------------
  // Instruction queue. Writes land at the clock edge, so a response is first
  // visible on the outputs the cycle after rvalid.
  // ---------------------------------------------------------------------------
  assign q_wentry = '{pc: f_rdata, instr: imem_rdata_i};

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_iqueue (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (accept),
    .wdata (q_wentry),
    .pop   (dequeue),
    .flush (redirect_i),
    .rdata (q_rdata),
    .count (q_count),
    .full  (q_full),
    .empty (q_empty)
  );

  assign q_head        = q_rdata;
  assign instr_valid_o = !q_empty;
  assign instr_o       = q_head.instr;
  assign instr_pc_o    = q_head.pc;

  // Status outputs of the FIFOs that the credit scheme makes redundant here.
  logic unused_fifo_status;
  assign unused_fifo_status = ^{f_count, f_full, f_empty, q_full};

endmodule : fetch_unit
